// File: rtl/ex_mem_pipe_stage.sv
// ---------------------------------------------------------------------------
// ex_mem_pipe_stage
//
// EX/MEM pipeline boundary register with valid/ready flow control. A main
// register drives the outputs, and a one-entry skid register catches the
// entry that arrives in the same cycle the memory stage first stalls. Because
// of the skid entry, in_ready depends only on registered state and never
// combinationally on out_ready. A synchronous flush kills both entries and
// any incoming one. A saturating counter tracks cycles in which an entry sits
// at the output while the memory stage is not ready.
//
// Ports:
//   clk        : clock, all state updates on rising edge
//   reset      : asynchronous, active-high reset
//   flush      : synchronous kill of held and incoming entries
//   in_valid   : execute stage presents an entry
//   in_ready   : stage can accept an entry this cycle (= ~skid_valid)
//   in_pc      : instruction PC
//   in_alu     : ALU result / effective address
//   in_data2   : store data (rs2)
//   in_rd      : destination register index
//   in_ctrl    : {branch, memread, memtoreg, memwrite, regwrite, zero}
//   out_valid  : entry present at output
//   out_ready  : memory stage consumes the entry
//   out_pc     : registered PC
//   out_alu    : registered ALU result
//   out_data2  : registered store data
//   out_rd     : registered destination register
//   out_ctrl   : registered control; side-effecting bits gated by out_valid
//   cnt_clr    : synchronous clear of stall_cnt
//   stall_cnt  : saturating count of cycles with out_valid & ~out_ready
// ---------------------------------------------------------------------------
module ex_mem_pipe_stage #(
  parameter int XLEN  = 64,
  parameter int RD_W  = 5,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [XLEN-1:0]  in_pc,
  input  logic [XLEN-1:0]  in_alu,
  input  logic [XLEN-1:0]  in_data2,
  input  logic [RD_W-1:0]  in_rd,
  input  logic [5:0]       in_ctrl,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_pc,
  output logic [XLEN-1:0]  out_alu,
  output logic [XLEN-1:0]  out_data2,
  output logic [RD_W-1:0]  out_rd,
  output logic [5:0]       out_ctrl,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] stall_cnt
);

  // Control bit positions inside the 6-bit control field.
  localparam int CTRL_BRANCH   = 5;
  localparam int CTRL_MEMREAD  = 4;
  localparam int CTRL_MEMTOREG = 3;
  localparam int CTRL_MEMWRITE = 2;
  localparam int CTRL_REGWRITE = 1;
  localparam int CTRL_ZERO     = 0;

  // Bits that cause side effects downstream and must read 0 on a bubble.
  localparam logic [5:0] CTRL_GATED_MASK = 6'b110110;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] alu;
    logic [XLEN-1:0] data2;
    logic [RD_W-1:0] rd;
    logic [5:0]      ctrl;
  } entry_t;

  // Storage
  entry_t           main_q,       main_d;
  entry_t           skid_q,       skid_d;
  logic             main_valid_q, main_valid_d;
  logic             skid_valid_q, skid_valid_d;
  logic [CNT_W-1:0] stall_cnt_q,  stall_cnt_d;

  // Handshake terms
  entry_t in_entry_s;
  logic   accept_s;
  logic   drain_s;
  logic   stalled_s;

  assign in_entry_s = '{pc: in_pc, alu: in_alu, data2: in_data2, rd: in_rd, ctrl: in_ctrl};

  // in_ready comes straight from a flop so the upstream ready path never
  // sees out_ready.
  assign in_ready  = ~skid_valid_q;
  assign accept_s  = in_valid & ~skid_valid_q;
  assign drain_s   = main_valid_q & out_ready;
  assign stalled_s = main_valid_q & ~out_ready;

  // Next state of the main and skid entries; flush dominates everything.
  always_comb begin
    main_d       = main_q;
    skid_d       = skid_q;
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    if (flush) begin
      // Only the valid bits are cleared; stale data is harmless behind them.
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (skid_valid_q && drain_s) begin
      // in_ready is low while the skid is full, so nothing is accepted here.
      main_d       = skid_q;
      main_valid_d = 1'b1;
      skid_valid_d = 1'b0;
    end else if (accept_s && (!main_valid_q || drain_s)) begin
      main_d       = in_entry_s;
      main_valid_d = 1'b1;
    end else if (accept_s) begin
      // Main is full and not draining: park the entry in the skid.
      skid_d       = in_entry_s;
      skid_valid_d = 1'b1;
    end else if (drain_s) begin
      main_valid_d = 1'b0;
    end else begin
      main_valid_d = main_valid_q;
    end
  end

  // Next value of the saturating stall counter; clear beats increment.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (cnt_clr) begin
      stall_cnt_d = {CNT_W{1'b0}};
    end else if (stalled_s && (stall_cnt_q != CNT_MAX)) begin
      stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
  end

  // State registers with asynchronous active-high reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      main_q       <= '0;
      skid_q       <= '0;
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      stall_cnt_q  <= {CNT_W{1'b0}};
    end else begin
      main_q       <= main_d;
      skid_q       <= skid_d;
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
      stall_cnt_q  <= stall_cnt_d;
    end
  end

  // Outputs are taken directly from the main register; the control gating
  // is an AND of two flop outputs.
  assign out_valid = main_valid_q;
  assign out_pc    = main_q.pc;
  assign out_alu   = main_q.alu;
  assign out_data2 = main_q.data2;
  assign out_rd    = main_q.rd;
  assign stall_cnt = stall_cnt_q;

  assign out_ctrl[CTRL_BRANCH]   = main_q.ctrl[CTRL_BRANCH]   & main_valid_q;
  assign out_ctrl[CTRL_MEMREAD]  = main_q.ctrl[CTRL_MEMREAD]  & main_valid_q;
  assign out_ctrl[CTRL_MEMTOREG] = main_q.ctrl[CTRL_MEMTOREG];
  assign out_ctrl[CTRL_MEMWRITE] = main_q.ctrl[CTRL_MEMWRITE] & main_valid_q;
  assign out_ctrl[CTRL_REGWRITE] = main_q.ctrl[CTRL_REGWRITE] & main_valid_q;
  assign out_ctrl[CTRL_ZERO]     = main_q.ctrl[CTRL_ZERO];

endmodule

// File: tb/tb_ex_mem_pipe_stage.sv
module tb_ex_mem_pipe_stage;

  localparam int XLEN  = 64;
  localparam int RD_W  = 5;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [XLEN-1:0]  in_pc;
  logic [XLEN-1:0]  in_alu;
  logic [XLEN-1:0]  in_data2;
  logic [RD_W-1:0]  in_rd;
  logic [5:0]       in_ctrl;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  out_pc;
  logic [XLEN-1:0]  out_alu;
  logic [XLEN-1:0]  out_data2;
  logic [RD_W-1:0]  out_rd;
  logic [5:0]       out_ctrl;
  logic             cnt_clr;
  logic [CNT_W-1:0] stall_cnt;

  int checks = 0;
  int errors = 0;

  ex_mem_pipe_stage #(.XLEN(XLEN), .RD_W(RD_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_alu(in_alu), .in_data2(in_data2), .in_rd(in_rd), .in_ctrl(in_ctrl),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_alu(out_alu), .out_data2(out_data2), .out_rd(out_rd), .out_ctrl(out_ctrl),
    .cnt_clr(cnt_clr), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [XLEN-1:0] alu_of(input logic [XLEN-1:0] pc);
    return pc ^ 64'hA5A5_0000_5A5A_0000;
  endfunction

  function automatic logic [RD_W-1:0] rd_of(input logic [XLEN-1:0] pc);
    return pc[6:2];
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [XLEN-1:0] pc, input logic [5:0] ctrl);
    in_valid = v;
    in_pc    = pc;
    in_alu   = alu_of(pc);
    in_data2 = ~pc;
    in_rd    = rd_of(pc);
    in_ctrl  = ctrl;
  endtask

  task automatic test_reset();
    reset = 1'b1; flush = 1'b0; cnt_clr = 1'b0; out_ready = 1'b1;
    drive(1'b0, 64'h0, 6'b000000);
    #3;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_pc !== 64'h0 || out_ctrl !== 6'h0 || stall_cnt !== 4'h0) begin
      errors++;
      $display("FAIL reset_state: valid=%b ready=%b pc=%h ctrl=%b cnt=%0d, want 0 1 0 0 0",
               out_valid, in_ready, out_pc, out_ctrl, stall_cnt);
    end
    cyc();
    reset = 1'b0;
  endtask

  task automatic test_stream();
    logic [XLEN-1:0] pc;
    logic [5:0]      ctrl;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      pc   = 64'h100 + 64'(4 * i);
      ctrl = (i == 3) ? 6'b111110 : 6'b111111;
      drive(1'b1, pc, ctrl);
      checks++;
      if (in_ready !== 1'b1) begin
        errors++;
        $display("FAIL stream_in_ready[%0d]: got %b want 1", i, in_ready);
      end
      cyc();
      checks++;
      if (out_valid !== 1'b1 || out_pc !== pc || out_alu !== alu_of(pc) || out_data2 !== ~pc ||
          out_rd !== rd_of(pc) || out_ctrl !== ctrl) begin
        errors++;
        $display("FAIL stream_out[%0d]: valid=%b pc=%h ctrl=%b, want 1 %h %b", i, out_valid, out_pc, out_ctrl, pc, ctrl);
      end
    end
    drive(1'b0, 64'h0, 6'b000000);
    cyc();
    checks++;
    if (out_valid !== 1'b0 || out_ctrl !== 6'b001000) begin
      errors++;
      $display("FAIL stream_drain_gating: valid=%b ctrl=%b, want 0 001000", out_valid, out_ctrl);
    end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    drive(1'b1, 64'h200, 6'b010101);
    cyc();
    drive(1'b1, 64'h204, 6'b101010);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_ready_one_held: got %b want 1", in_ready);
    end
    cyc();
    drive(1'b0, 64'h0, 6'b000000);
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_pc !== 64'h200) begin
      errors++;
      $display("FAIL bp_full: ready=%b valid=%b pc=%h, want 0 1 200", in_ready, out_valid, out_pc);
    end
    cyc();
    checks++;
    if (out_pc !== 64'h200 || out_alu !== alu_of(64'h200) || out_ctrl !== 6'b010101) begin
      errors++;
      $display("FAIL bp_hold_stable: pc=%h ctrl=%b, want 200 010101", out_pc, out_ctrl);
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL bp_no_comb_ready: got %b want 0", in_ready);
    end
    cyc();
    checks++;
    if (out_valid !== 1'b1 || out_pc !== 64'h204 || out_ctrl !== 6'b101010 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_skid_out: valid=%b pc=%h ready=%b, want 1 204 1", out_valid, out_pc, in_ready);
    end
    cyc();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_empty: valid=%b want 0", out_valid);
    end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    drive(1'b1, 64'h300, 6'b111111);
    cyc();
    drive(1'b1, 64'h304, 6'b111111);
    cyc();
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL flush_prefull: ready=%b want 0", in_ready);
    end
    drive(1'b1, 64'h308, 6'b111111);
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    drive(1'b0, 64'h0, 6'b000000);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_ctrl[2] !== 1'b0 || out_ctrl[1] !== 1'b0) begin
      errors++;
      $display("FAIL flush_clear: valid=%b ready=%b ctrl=%b, want 0 1 xx00x", out_valid, in_ready, out_ctrl);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL flush_no_ghost[%0d]: valid=%b pc=%h want valid 0", i, out_valid, out_pc);
      end
    end
    drive(1'b1, 64'h30C, 6'b000010);
    cyc();
    drive(1'b0, 64'h0, 6'b000000);
    checks++;
    if (out_valid !== 1'b1 || out_pc !== 64'h30C) begin
      errors++;
      $display("FAIL flush_resume: valid=%b pc=%h, want 1 30c", out_valid, out_pc);
    end
    cyc();
  endtask

  task automatic test_stall_cnt();
    out_ready = 1'b0;
    cnt_clr = 1'b1;
    cyc();
    cnt_clr = 1'b0;
    checks++;
    if (stall_cnt !== 4'd0) begin
      errors++;
      $display("FAIL cnt_initial_clear: got %0d want 0", stall_cnt);
    end
    drive(1'b1, 64'h400, 6'b000001);
    cyc();
    drive(1'b0, 64'h0, 6'b000000);
    checks++;
    if (stall_cnt !== 4'd0 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL cnt_load: cnt=%0d valid=%b, want 0 1", stall_cnt, out_valid);
    end
    for (int i = 1; i <= 20; i++) begin
      cyc();
      if (i == 10) begin
        checks++;
        if (stall_cnt !== 4'd10) begin
          errors++;
          $display("FAIL cnt_count10: got %0d want 10", stall_cnt);
        end
      end
    end
    checks++;
    if (stall_cnt !== 4'd15) begin
      errors++;
      $display("FAIL cnt_saturate: got %0d want 15", stall_cnt);
    end
    cnt_clr = 1'b1;
    cyc();
    cnt_clr = 1'b0;
    checks++;
    if (stall_cnt !== 4'd0) begin
      errors++;
      $display("FAIL cnt_clr: got %0d want 0", stall_cnt);
    end
    cyc();
    checks++;
    if (stall_cnt !== 4'd1) begin
      errors++;
      $display("FAIL cnt_resume: got %0d want 1", stall_cnt);
    end
  endtask

  task automatic test_async_reset();
    drive(1'b1, 64'h404, 6'b000000);
    cyc();
    drive(1'b0, 64'h0, 6'b000000);
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL areset_prefull: ready=%b valid=%b, want 0 1", in_ready, out_valid);
    end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || stall_cnt !== 4'd0 || in_ready !== 1'b1 || out_pc !== 64'h0) begin
      errors++;
      $display("FAIL areset_immediate: valid=%b cnt=%0d ready=%b pc=%h, want 0 0 1 0",
               out_valid, stall_cnt, in_ready, out_pc);
    end
    #2;
    reset = 1'b0;
    cyc();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL areset_after: valid=%b ready=%b, want 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_random();
    logic [XLEN-1:0] q[$];
    logic [XLEN-1:0] next_pc;
    logic            ir;
    logic            acc;
    logic            drn;
    next_pc = 64'h1000;
    q.delete();
    for (int c = 0; c < 10000 + 10; c++) begin
      if (c < 10000) begin
        drive($urandom_range(0, 9) < 6, next_pc, next_pc[7:2]);
        out_ready = $urandom_range(0, 3) != 0;
      end else begin
        drive(1'b0, 64'h0, 6'b000000);
        out_ready = 1'b1;
      end
      #1;
      checks++;
      if (in_ready !== (q.size() < 2) || out_valid !== (q.size() > 0)) begin
        errors++;
        $display("FAIL rand_flags[%0d]: ready=%b valid=%b, occupancy %0d", c, in_ready, out_valid, q.size());
      end
      if (q.size() > 0) begin
        checks++;
        if (out_pc !== q[0] || out_rd !== rd_of(q[0]) || out_alu !== alu_of(q[0]) || out_ctrl !== q[0][7:2]) begin
          errors++;
          $display("FAIL rand_data[%0d]: pc=%h rd=%h ctrl=%b, want pc %h", c, out_pc, out_rd, out_ctrl, q[0]);
        end
      end
      ir = in_ready;
      out_ready = ~out_ready;
      #1;
      checks++;
      if (in_ready !== ir) begin
        errors++;
        $display("FAIL rand_ready_comb[%0d]: in_ready moved to %b with out_ready, want %b", c, in_ready, ir);
      end
      out_ready = ~out_ready;
      #1;
      acc = in_valid && (q.size() < 2);
      drn = (q.size() > 0) && out_ready;
      if (drn) void'(q.pop_front());
      if (acc) begin
        q.push_back(next_pc);
        next_pc = next_pc + 64'h4;
      end
      cyc();
    end
    checks++;
    if (q.size() != 0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL rand_final_drain: left %0d valid=%b, want 0 0", q.size(), out_valid);
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_flush();
    test_stall_cnt();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
